// File: rtl/mdu.sv
// Iterative RV32M/RV64M multiply/divide unit. One shared shift datapath runs one bit
// per cycle; operands are folded to magnitudes at accept and the sign is fixed at the end.
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] A_i,
    input  logic [XLEN-1:0] B_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    // Handshakes: issue transfers on posedge with valid_i && ready_o (and no flush_i);
    // writeback transfers on posedge with valid_o && ready_i. Neither valid waits on ready.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     d_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_q;
    logic                valid_q;
    logic [XLEN-1:0]     result_q;

    logic                a_signed, b_signed, a_neg, b_neg, sign_d;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                is_div, div_zero, div_ovf;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, acc_d, prod;
    logic [XLEN-1:0]     quo, rem, final_res;

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

    always_comb begin
        a_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
        b_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
        a_neg    = a_signed && A_i[XLEN-1];
        b_neg    = b_signed && B_i[XLEN-1];
        a_mag    = a_neg ? -A_i : A_i;
        b_mag    = b_neg ? -B_i : B_i;
        // Remainders follow the dividend's sign; products and quotients the xor.
        sign_d   = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);

        is_div   = op_i[2];
        div_zero = is_div && (B_i == '0);
        div_ovf  = is_div && !op_i[0] && (A_i == {1'b1, {(XLEN-1){1'b0}}}) && (&B_i);
        if (div_zero) special_res = op_i[1] ? A_i : '1;
        else          special_res = op_i[1] ? '0 : A_i;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, d_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, d_q};
        div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
        acc_d     = op_q[2] ? div_next : mul_next;

        prod = neg_q ? -acc_d : acc_d;
        quo  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem  = neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            d_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (valid_i) begin
                    op_q  <= op_i;
                    neg_q <= sign_d;
                    cnt_q <= CW'(XLEN-1);
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                    d_q   <= is_div ? b_mag : a_mag;
                    acc_q <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                    if (div_zero || div_ovf) begin
                        result_q <= special_res;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        result_q <= final_res;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: if (ready_i) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Directed and randomized bench for mdu; results come from a plain-arithmetic model.
module tb_mdu;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni, valid_i, ready_i, flush_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] A_i, B_i;
    logic            ready_o, valid_o;
    logic [XLEN-1:0] result_o;

    int n_vec = 0;
    int n_err = 0;

    mdu #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .A_i(A_i), .B_i(B_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic signed [31:0] sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (op == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        case (op)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int lat, exp_lat;
        exp     = ref_model(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : XLEN + 1;
        chk("ready_before_accept", 32'(ready_o), 32'd1);
        valid_i = 1'b1; op_i = op; A_i = a; B_i = b;
        @(posedge clk_i); @(negedge clk_i);
        valid_i = 1'b0; op_i = 3'($urandom); A_i = $urandom; B_i = $urandom;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk_i); @(negedge clk_i);
            lat++;
        end
        chk($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
        chk($sformatf("result op%0d a=%h b=%h", op, a, b), result_o, exp);
        for (int i = 0; i < hold; i++) begin
            valid_i = 1'b1; op_i = 3'($urandom); A_i = $urandom; B_i = $urandom;
            @(posedge clk_i); @(negedge clk_i);
            valid_i = 1'b0;
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_result", result_o, exp);
            chk("hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        ready_i = 1'b0;
        chk("post_handoff_ready", 32'(ready_o), 32'd1);
        chk("post_handoff_valid", 32'(valid_o), 32'd0);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i); @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        op_i = '0; A_i = '0; B_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_ready", 32'(ready_o), 32'd1);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b100, 32'd5, 32'd0, 0);
        run_op(3'b101, 32'd5, 32'd0, 0);
        run_op(3'b110, 32'd5, 32'd0, 0);
        run_op(3'b111, 32'd5, 32'd0, 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5);

        // Flush ten cycles into a divide.
        valid_i = 1'b1; op_i = 3'b100; A_i = 32'd1000; B_i = 32'd7;
        @(posedge clk_i); @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        flush_i = 1'b0;
        chk("flush_ready", 32'(ready_o), 32'd1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        watch_no_valid("flush_no_result", 40);
        run_op(3'b110, 32'd1000, 32'd7, 0);

        // Flush coincident with an offer in IDLE must not accept.
        flush_i = 1'b1; valid_i = 1'b1; op_i = 3'b100; A_i = 32'd9; B_i = 32'd0;
        @(posedge clk_i); @(negedge clk_i);
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush_offer_ready", 32'(ready_o), 32'd1);
        watch_no_valid("flush_offer_no_result", 40);

        // Reset twenty cycles into a multiply.
        valid_i = 1'b1; op_i = 3'b000; A_i = 32'd123; B_i = 32'd456;
        @(posedge clk_i); @(negedge clk_i);
        valid_i = 1'b0;
        repeat (19) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        chk("midreset_ready", 32'(ready_o), 32'd1);
        chk("midreset_valid", 32'(valid_o), 32'd0);
        chk("midreset_result", result_o, 32'd0);
        watch_no_valid("midreset_no_result", 40);
        run_op(3'b000, 32'd123, 32'd456, 0);

        for (int i = 0; i < 80; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
